sort_engine: RTL and testbench

Parametrised streaming sorter, the successor to the fixed 32-entry `sort_top`. It accepts up to DEPTH unsigned words over a valid/ready input stream and sorts them in place with odd-even transposition. It then streams the result out over a valid/ready output stream, in ascending or descending order, selected per job. It sits between a data source and a consumer, and one job runs at a time.

---
 rtl/sort_engine_if.sv | 31 +++
 rtl/sort_engine.sv | 140 ++++++++++++++
 tb/tb_sort_engine.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_engine_if.sv
// sort_engine_if: handshake bundle between a data source/consumer and sort_engine.
// Carries the job start controls, the input word stream, the sorted output stream
// and the status flags.
interface sort_engine_if #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 9
);
    logic                 go;
    logic [CNTWIDTH-1:0]  n;
    logic                 descend;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATAWIDTH-1:0] sorted_data;
    logic                 busy;
    logic                 done;

    // Source/consumer side
    modport master (
        output go, n, descend, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sorted_data, busy, done
    );

    // Sorter side
    modport slave (
        input  go, n, descend, in_valid, in_data, out_ready,
        output in_ready, out_valid, sorted_data, busy, done
    );
endinterface

// File: rtl/sort_engine.sv
// sort_engine: streaming odd-even transposition sorter.
// Loads up to DEPTH words, sorts them in place one phase per cycle, then streams
// them out ascending or descending (selected per job).
// Optional macro SORT_EARLY_EXIT_EN: leave SORT once an even and an odd phase in a
// row made no swap (the array is then already ordered).
module sort_engine #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 32,
    parameter int CNTWIDTH  = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sort_engine_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SORT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]           r_state;
    logic [CNTWIDTH-1:0]  r_n_eff;
    logic                 r_desc;
    logic [IW-1:0]        r_idx;     // load index in LOAD, output index in OUT
    logic [IW-1:0]        r_phase;
    logic                 r_done;
    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    logic [DATAWIDTH-1:0] w_mem [DEPTH];
    logic [CNTWIDTH-1:0]  w_n_clip;
    logic                 w_idx_last;
    logic                 w_phase_last;
    logic                 w_sort_exit;

    assign w_n_clip     = (bus.n > CNTWIDTH'(DEPTH)) ? CNTWIDTH'(DEPTH) : bus.n;
    assign w_idx_last   = (CNTWIDTH'(r_idx) == r_n_eff - CNTWIDTH'(1));
    assign w_phase_last = (CNTWIDTH'(r_phase) == r_n_eff - CNTWIDTH'(1));

`ifdef SORT_EARLY_EXIT_EN
    logic w_any_swap;
    logic r_quiet;   // previous phase of this job made no swap
    assign w_sort_exit = w_phase_last || (r_quiet && !w_any_swap);
`else
    assign w_sort_exit = w_phase_last;
`endif

    // One compare-exchange phase: pairs start on even or odd indices by phase parity;
    // pairs reaching past n_eff are left untouched. Pairs are disjoint within a phase.
    always_comb begin
        w_mem = r_mem;
`ifdef SORT_EARLY_EXIT_EN
        w_any_swap = 1'b0;
`endif
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (i[0] == r_phase[0] && CNTWIDTH'(i + 1) < r_n_eff) begin
                if (r_desc ? (r_mem[i] < r_mem[i+1]) : (r_mem[i] > r_mem[i+1])) begin
                    w_mem[i]   = r_mem[i+1];
                    w_mem[i+1] = r_mem[i];
`ifdef SORT_EARLY_EXIT_EN
                    w_any_swap = 1'b1;
`endif
                end
            end
        end
    end

    // Job FSM: IDLE -> LOAD -> SORT -> OUT -> IDLE, with storage and counters
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_n_eff <= '0;
            r_desc  <= 1'b0;
            r_idx   <= '0;
            r_phase <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
`ifdef SORT_EARLY_EXIT_EN
            r_quiet <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.go && bus.n != '0) begin
                        r_n_eff <= w_n_clip;
                        r_desc  <= bus.descend;
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_mem[r_idx] <= bus.in_data;
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_phase <= '0;
                            r_state <= S_SORT;
`ifdef SORT_EARLY_EXIT_EN
                            r_quiet <= 1'b0;
`endif
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    r_mem <= w_mem;
`ifdef SORT_EARLY_EXIT_EN
                    r_quiet <= !w_any_swap;
`endif
                    if (w_sort_exit) begin
                        r_phase <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_phase <= r_phase + IW'(1);
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        if (w_idx_last) begin
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_LOAD);
    assign bus.out_valid   = (r_state == S_OUT);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.sorted_data = (r_state == S_OUT) ? r_mem[r_idx] : '0;
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: randomized jobs against a queue/insertion-sort reference,
// plus literal expectations for the documented scenarios.
module tb_sort_engine;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int CW    = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_engine_if #(.DATAWIDTH(DW), .CNTWIDTH(CW)) bus ();

    sort_engine #(.DATAWIDTH(DW), .DEPTH(DEPTH), .CNTWIDTH(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int got_q[$];
    int vals[$];
    bit exp_done = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int sort_cyc = 0;
    int last_lat = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor: every cycle, compare the output stream against the model queue
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("done", {31'd0, bus.done}, {31'd0, exp_done});
            if (exp_done) check("busy_in_done_cycle", {31'd0, bus.busy}, 32'd0);
            exp_done = 1'b0;
            if (!bus.out_valid) check("data_zero_when_invalid", {24'd0, bus.sorted_data}, 32'd0);
            if (prev_stall && bus.out_valid)
                check("stall_hold", {24'd0, bus.sorted_data}, {24'd0, prev_data});
            if (bus.in_ready && bus.out_valid) check("ready_valid_exclusive", 32'd1, 32'd0);
            if (bus.busy && !bus.in_ready && !bus.out_valid) sort_cyc++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    check("out_data", {24'd0, bus.sorted_data}, exp_q.pop_front());
                    got_q.push_back(int'(bus.sorted_data));
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.sorted_data;
        end
    end

    // Runs one job from the current cycle (posedge+1); returns in the done cycle.
    // stall: 0 = out_ready held high, 1 = toggling, 2 = random
    task automatic run_job(input int n, input bit desc, input bit gaps, input int stall);
        int s[64];
        int neff, k, cyc, key, j;
        time t_go, t_v;
        neff = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < neff; i++) s[i] = vals[i];
        for (int i = 1; i < neff; i++) begin
            key = s[i];
            j = i - 1;
            while (j >= 0 && (desc ? (s[j] < key) : (s[j] > key))) begin
                s[j+1] = s[j];
                j--;
            end
            s[j+1] = key;
        end
        got_q.delete();
        bus.go = 1'b1; bus.n = CW'(n); bus.descend = desc;
        @(posedge clk); t_go = $time; #1;
        bus.go = 1'b0; bus.n = CW'($urandom); bus.descend = 1'($urandom);
        sort_cyc = 0;
        for (int i = 0; i < neff; i++) exp_q.push_back(s[i]);
        k = 0; cyc = 0;
        while (k < neff && cyc < 1000) begin
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data  = DW'(vals[k]);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("words_loaded", k, neff);
        @(negedge clk);
        check("in_ready_after_load", {31'd0, bus.in_ready}, 32'd0);
        check("busy_in_sort", {31'd0, bus.busy}, 32'd1);
        k = 0; cyc = 0; t_v = 0;
        while (k < neff && cyc < 2000) begin
            @(posedge clk); #1;
            bus.out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? ~bus.out_ready : 1'($urandom);
            @(negedge clk);
            if (bus.out_valid && t_v == 0) t_v = $time;
            if (bus.out_valid && bus.out_ready) k++;
            cyc++;
        end
        check("output_count", k, neff);
`ifdef SORT_EARLY_EXIT_EN
        check("sort_cycles_bounded", {31'd0, sort_cyc >= 1 && sort_cyc <= neff}, 32'd1);
`else
        check("sort_cycles", sort_cyc, neff);
`endif
        last_lat = int'((t_v - t_go + 5) / 10);
        if (!gaps) check("first_out_latency", last_lat, 1 + neff + sort_cyc);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lit6[6];
        int nn;
        lit6 = '{255, 9, 9, 5, 5, 0};
        bus.go = 0; bus.n = '0; bus.descend = 0; bus.in_valid = 0; bus.in_data = '0;
        bus.out_ready = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_sorted_data", {24'd0, bus.sorted_data}, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // Reset in the middle of a load
        bus.go = 1; bus.n = 9'd32;
        @(posedge clk); #1; bus.go = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1; bus.in_data = DW'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 0; rst = 1'b0;
        @(posedge clk); #1;
        check("midload_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("midload_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midload_rst_data", {24'd0, bus.sorted_data}, 32'd0);
        rst = 1'b1;
        idle(1);
        vals = '{3, 1, 2, 0};
        run_job(4, 0, 0, 0);
        for (int i = 0; i < 4; i++) check("after_rst_job", got_q[i], i);
        idle(2);

        // Full depth ascending, then a back-to-back job started in the done cycle
        vals.delete();
        for (int i = 0; i < 32; i++) vals.push_back(31 - i);
        run_job(32, 0, 0, 0);
        for (int i = 0; i < 32; i++) check("full_depth_asc", got_q[i], i);
`ifndef SORT_EARLY_EXIT_EN
        check("full_depth_latency", last_lat, 65);
`endif
        vals = '{7, 3};
        run_job(2, 0, 0, 0);
        check("b2b_0", got_q[0], 3);
        check("b2b_1", got_q[1], 7);
        idle(2);

        // Descending with duplicates and toggling back-pressure
        vals = '{5, 9, 5, 0, 255, 9};
        run_job(6, 1, 0, 1);
        for (int i = 0; i < 6; i++) check("desc_dups", got_q[i], lit6[i]);
        idle(2);

        // n = 0 is ignored
        bus.go = 1; bus.n = '0;
        @(posedge clk); #1; bus.go = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("n0_busy", {31'd0, bus.busy}, 32'd0);
            @(posedge clk); #1;
        end

        // Oversize count clips to DEPTH
        vals.delete();
        for (int i = 0; i < 40; i++) vals.push_back(int'($urandom_range(0, 255)));
        run_job(40, 0, 0, 2);
        check("oversize_count", got_q.size(), 32);
        idle(2);

        // Already sorted input (early exit when enabled)
        vals.delete();
        for (int i = 0; i < 32; i++) vals.push_back(i);
        run_job(32, 0, 0, 0);
        for (int i = 0; i < 32; i++) check("presorted", got_q[i], i);
`ifdef SORT_EARLY_EXIT_EN
        check("presorted_sort_cycles", sort_cyc, 2);
`else
        check("presorted_sort_cycles", sort_cyc, 32);
`endif
        idle(2);

        // Single element
        vals = '{42};
        run_job(1, 1, 0, 0);
        check("single_sort_cycles", sort_cyc, 1);
        check("single_word", got_q[0], 42);
        idle(1);

        // Randomized jobs
        for (int t = 0; t < 25; t++) begin
            nn = int'($urandom_range(1, 40));
            vals.delete();
            for (int i = 0; i < nn; i++)
                vals.push_back(int'((t % 2) ? $urandom_range(0, 7) : $urandom_range(0, 255)));
            run_job(nn, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
